learn_sequencer: RTL and testbench
==================================

Name: learn_sequencer

Overview:
- Upstream stage of the LED driver.
- In LEARN_MODE it steps through a stored song and drives the expected note on LEARNBusline.
- It watches the player's live BUZZERBusline. A correct note advances the song; a missed note times out and advances anyway.
- It keeps hit and miss tallies, and raises song_done at the end of the song.

Parameters:
- TICK_DIV, 25_000_000: clk cycles per beat tick (250 ms at 100 MHz). Benches use 4.
- MISS_BEATS, 8: beats a note is shown before it counts as a miss.
- SONG_LEN, 64: entries per song (address width 6).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- Status  in  2  mode from mode controller (`FREE_MODE/`UART_MODE/`LEARN_MODE/`PLAY_MODE)
- song_sel  in  2  song index, sampled on entry to learning
- BUZZERBusline  in  10  live key bus; [6:0] notes do..si, [9:7] octave/accidental modifiers
- LEARNBusline  out  10  expected note pattern, same encoding
- song_done  out  1  high in DONE
- hit_cnt  out  8  correct notes, saturating
- miss_cnt  out  8  timed-out notes, saturating

Behaviour:
Clock and reset:
- Single clk domain.
- rst is async, active-high. It forces state=IDLE, LEARNBusline=0, song_done=0, hit_cnt=0, miss_cnt=0, addr=0, beat prescaler=0, beat counter=0.

Song storage and matching:
- ROM word is 14 bits: {dur[3:0], note[9:0]}. dur is informational only.
- The end marker is note==10'h000.
- ROM read is synchronous with 1-cycle latency.
- A hit is exact 10-bit equality BUZZERBusline==LEARNBusline, with LEARNBusline non-zero.

Beat tick:
- Prescaler counts 0..TICK_DIV-1 and pulses tick for 1 cycle on wrap.
- It runs only in SHOW and is cleared on every entry to SHOW.

FSM (registered, one transition per cycle):
- IDLE: outputs LEARNBusline=0. When Status==`LEARN_MODE: latch song_sel, clear hit_cnt/miss_cnt, addr=0, go to LOAD.
- LOAD: issue ROM read at {song_sel,addr}, go to FETCH.
- FETCH: ROM data valid.
  - If note==0, go to DONE.
  - Else LEARNBusline<=note, beat counter=0, go to SHOW.
- SHOW:
  - On hit: hit_cnt+1 (saturating at 255), go to RELEASE.
  - Else on tick: beat counter+1. When it reaches MISS_BEATS, miss_cnt+1 (saturating), go to RELEASE.
  - A hit and the final tick in the same cycle count as a hit only.
- RELEASE: LEARNBusline<=0. Wait until BUZZERBusline==0. This stops a held key from scoring the next identical note.
  - If addr==SONG_LEN-1, go to DONE (wrap-around is never taken).
  - Else addr+1, go to LOAD.
- DONE: song_done=1, LEARNBusline=0, counters held. Stays until Status leaves `LEARN_MODE.

Mode changes and latency:
- In any non-IDLE state, Status!=`LEARN_MODE returns to IDLE on the next edge, with LEARNBusline=0 and song_done=0. hit_cnt and miss_cnt are held for display.
- song_sel changes mid-song are ignored until the next entry.
- Latency from entering LEARN_MODE to the first note on LEARNBusline is 3 cycles (IDLE→LOAD→FETCH→SHOW).
- Latency from a hit to LEARNBusline clearing is 1 cycle.

Decomposition:
- Shared package: the mode codes `FREE_MODE=2'b00, `UART_MODE=2'b01, `LEARN_MODE=2'b10, `PLAY_MODE=2'b11 already live in para.v and are used as-is.
- Add to para.v:
  - note bit positions `NOTE_DO..`NOTE_SI=0..6 and `MOD_HI=7, `MOD_LO=8, `MOD_SHARP=9;
  - the END_MARK constant 10'h000;
  - the state encodings S_IDLE..S_DONE.
- Sub-module learn_song_rom: 256x14 synchronous ROM, addr[7:0]={song_sel,addr}, initialised from a case table. Song 3 is a 3-note bench song: 10'h001, 10'h002, 10'h004, END.

Test Plan (TICK_DIV=4, MISS_BEATS=8, song_sel=3):
- Reset mid-SHOW: assert rst asynchronously between edges → LEARNBusline=0, hit_cnt=0, song_done=0 immediately, without waiting for a clock edge.
- Status=`LEARN_MODE, correct keys with releases → LEARNBusline shows 001, 002, 004 in order; hit_cnt=3, miss_cnt=0, song_done=1.
- No keys pressed → each note held for 32 cycles (8 beats x 4) then cleared; miss_cnt=3, song_done=1.
- Hold key 10'h001 through the first note → hit on note 1. The FSM stays in RELEASE until the key is released; note 2 is not shown while the key is held.
- Wrong key 10'h081 (do + high) on note 1 → no hit; miss after 32 cycles.
- Status to `FREE_MODE while showing note 2 → IDLE next edge, LEARNBusline=0, hit_cnt holds 1. Re-entering `LEARN_MODE clears the counters and restarts at note 1.

Source files
------------

// File: rtl/learn_sequencer_pkg.sv
// Shared mode codes, note encoding, FSM states and song ROM word layout.
package learn_sequencer_pkg;

  localparam int unsigned NOTE_W = 10;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned ROM_AW = 8;

  localparam logic [1:0] FREE_MODE  = 2'b00;
  localparam logic [1:0] UART_MODE  = 2'b01;
  localparam logic [1:0] LEARN_MODE = 2'b10;
  localparam logic [1:0] PLAY_MODE  = 2'b11;

  localparam int unsigned NOTE_DO   = 0;
  localparam int unsigned NOTE_RE   = 1;
  localparam int unsigned NOTE_MI   = 2;
  localparam int unsigned NOTE_FA   = 3;
  localparam int unsigned NOTE_SO   = 4;
  localparam int unsigned NOTE_LA   = 5;
  localparam int unsigned NOTE_SI   = 6;
  localparam int unsigned MOD_HI    = 7;
  localparam int unsigned MOD_LO    = 8;
  localparam int unsigned MOD_SHARP = 9;

  localparam logic [NOTE_W-1:0] END_MARK = 10'h000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FETCH   = 3'd2,
    S_SHOW    = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] note;
  } rom_word_t;

  // One-hot key pattern for a bit position of the key bus
  function automatic logic [NOTE_W-1:0] key(input int unsigned pos);
    return NOTE_W'(1) << pos;
  endfunction

  function automatic rom_word_t mk_word(input logic [DUR_W-1:0] dur,
                                        input logic [NOTE_W-1:0] note);
    rom_word_t w;
    w.dur  = dur;
    w.note = note;
    return w;
  endfunction

endpackage

// File: rtl/learn_song_rom.sv
// 256x14 synchronous song ROM; address is {song_sel, note index}.
module learn_song_rom
  import learn_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output rom_word_t         data
);

  // Song table; unlisted locations read as the end marker
  function automatic rom_word_t lookup(input logic [ROM_AW-1:0] a);
    rom_word_t w;
    w = mk_word(4'd0, END_MARK);
    case (a)
      // song 0: opening of a nursery tune
      8'h00: w = mk_word(4'd2, key(NOTE_DO));
      8'h01: w = mk_word(4'd2, key(NOTE_DO));
      8'h02: w = mk_word(4'd2, key(NOTE_SO));
      8'h03: w = mk_word(4'd2, key(NOTE_SO));
      8'h04: w = mk_word(4'd2, key(NOTE_LA));
      8'h05: w = mk_word(4'd2, key(NOTE_LA));
      8'h06: w = mk_word(4'd4, key(NOTE_SO));
      // song 1: rising scale ending on high do
      8'h40: w = mk_word(4'd1, key(NOTE_DO));
      8'h41: w = mk_word(4'd1, key(NOTE_RE));
      8'h42: w = mk_word(4'd1, key(NOTE_MI));
      8'h43: w = mk_word(4'd1, key(NOTE_FA));
      8'h44: w = mk_word(4'd1, key(NOTE_SO));
      8'h45: w = mk_word(4'd1, key(NOTE_LA));
      8'h46: w = mk_word(4'd1, key(NOTE_SI));
      8'h47: w = mk_word(4'd4, key(NOTE_DO) | key(MOD_HI));
      // song 2: sharps and low octave
      8'h80: w = mk_word(4'd2, key(NOTE_DO) | key(MOD_SHARP));
      8'h81: w = mk_word(4'd2, key(NOTE_MI) | key(MOD_LO));
      8'h82: w = mk_word(4'd4, key(NOTE_SO) | key(MOD_SHARP));
      // song 3: short three-note song
      8'hC0: w = mk_word(4'd1, 10'h001);
      8'hC1: w = mk_word(4'd1, 10'h002);
      8'hC2: w = mk_word(4'd1, 10'h004);
      default: w = mk_word(4'd0, END_MARK);
    endcase
    return w;
  endfunction

  // Registered read: data is valid one cycle after addr
  always_ff @(posedge clk) begin
    data <= lookup(addr);
  end

endmodule

// File: rtl/learn_sequencer.sv
// Learn-mode sequencer: shows the expected note, scores hits and timeouts.
module learn_sequencer
  import learn_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned MISS_BEATS = 8,
  parameter int unsigned SONG_LEN   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        Status,
  input  logic [SEL_W-1:0]  song_sel,
  input  logic [NOTE_W-1:0] BUZZERBusline,
  output logic [NOTE_W-1:0] LEARNBusline,
  output logic              song_done,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
);

  localparam int unsigned AW = $clog2(SONG_LEN);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = $clog2(MISS_BEATS + 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [NOTE_W-1:0] note_d;
  logic              done_d;
  logic [7:0]        hit_d, miss_d;
  logic              tick_c;
  logic              hit_c;
  rom_word_t         rom_q;
  logic              unused_dur;

  learn_song_rom u_rom (
    .clk  (clk),
    .addr (ROM_AW'({sel_q, addr_q})),
    .data (rom_q)
  );

  // Duration field is carried in the ROM but not used for timing
  assign unused_dur = ^rom_q.dur;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      sel_q        <= '0;
      presc_q      <= '0;
      beat_q       <= '0;
      LEARNBusline <= '0;
      song_done    <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      presc_q      <= presc_d;
      beat_q       <= beat_d;
      LEARNBusline <= note_d;
      song_done    <= done_d;
      hit_cnt      <= hit_d;
      miss_cnt     <= miss_d;
    end
  end

  // Next-state, beat timing and scoring
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    presc_d = presc_q;
    beat_d  = beat_q;
    note_d  = LEARNBusline;
    done_d  = song_done;
    hit_d   = hit_cnt;
    miss_d  = miss_cnt;
    tick_c  = 1'b0;
    hit_c   = (BUZZERBusline == LEARNBusline) && (LEARNBusline != END_MARK);

    if ((state_q != S_IDLE) && (Status != LEARN_MODE)) begin
      // Leaving learn mode: blank the bus, keep tallies for display
      state_d = S_IDLE;
      note_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          note_d = '0;
          done_d = 1'b0;
          if (Status == LEARN_MODE) begin
            sel_d   = song_sel;
            addr_d  = '0;
            hit_d   = '0;
            miss_d  = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (rom_q.note == END_MARK) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            note_d  = rom_q.note;
            beat_d  = '0;
            presc_d = '0;
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_c  = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // A hit wins over a coincident final tick
          if (hit_c) begin
            hit_d   = (hit_cnt == 8'hFF) ? hit_cnt : hit_cnt + 8'd1;
            note_d  = '0;
            state_d = S_RELEASE;
          end else if (tick_c) begin
            beat_d = beat_q + BW'(1);
            if (beat_q == BW'(MISS_BEATS - 1)) begin
              miss_d  = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
              note_d  = '0;
              state_d = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          // Hold here until all keys are up so a held key cannot score twice
          note_d = '0;
          if (BUZZERBusline == '0) begin
            if (addr_q == AW'(SONG_LEN - 1)) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + AW'(1);
              state_d = S_LOAD;
            end
          end
        end
        S_DONE: begin
          note_d = '0;
          done_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_learn_sequencer.sv
// Directed bench for learn_sequencer using the three-note song 3.
module tb_learn_sequencer;
  import learn_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] Status;
  logic [1:0] song_sel;
  logic [9:0] BUZZERBusline;
  logic [9:0] LEARNBusline;
  logic       song_done;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  learn_sequencer #(
    .TICK_DIV   (4),
    .MISS_BEATS (8),
    .SONG_LEN   (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Status        (Status),
    .song_sel      (song_sel),
    .BUZZERBusline (BUZZERBusline),
    .LEARNBusline  (LEARNBusline),
    .song_done     (song_done),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] status;
    logic [9:0] buzz;
    logic [9:0] note;
    logic       done;
    logic [7:0] hit;
    logic [7:0] miss;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a note to appear, checks its value and how many cycles it stays
  task automatic measure(input logic [9:0] exp_note, input string name);
    int wait_c;
    int len;
    wait_c = 0;
    len    = 0;
    while (LEARNBusline == 10'h000 && wait_c < 20) begin
      step();
      wait_c++;
    end
    chk({name, "_note"}, int'(LEARNBusline), int'(exp_note));
    while (LEARNBusline == exp_note && len < 100) begin
      step();
      len++;
    end
    chk({name, "_len"}, len, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int held_bad;

    // Song 3 played correctly, with one key held over into release
    vecs[0]  = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{LEARN_MODE, 10'h000, 10'h001, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{LEARN_MODE, 10'h001, 10'h000, 1'b0, 8'd1, 8'd0};
    vecs[4]  = '{LEARN_MODE, 10'h001, 10'h000, 1'b0, 8'd1, 8'd0};
    vecs[5]  = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd1, 8'd0};
    vecs[6]  = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd1, 8'd0};
    vecs[7]  = '{LEARN_MODE, 10'h000, 10'h002, 1'b0, 8'd1, 8'd0};
    vecs[8]  = '{LEARN_MODE, 10'h002, 10'h000, 1'b0, 8'd2, 8'd0};
    vecs[9]  = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd2, 8'd0};
    vecs[10] = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd2, 8'd0};
    vecs[11] = '{LEARN_MODE, 10'h000, 10'h004, 1'b0, 8'd2, 8'd0};
    vecs[12] = '{LEARN_MODE, 10'h004, 10'h000, 1'b0, 8'd3, 8'd0};
    vecs[13] = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd3, 8'd0};
    vecs[14] = '{LEARN_MODE, 10'h000, 10'h000, 1'b0, 8'd3, 8'd0};
    vecs[15] = '{LEARN_MODE, 10'h000, 10'h000, 1'b1, 8'd3, 8'd0};
    vecs[16] = '{LEARN_MODE, 10'h000, 10'h000, 1'b1, 8'd3, 8'd0};
    vecs[17] = '{FREE_MODE,  10'h000, 10'h000, 1'b0, 8'd3, 8'd0};

    rst           = 1'b1;
    Status        = FREE_MODE;
    song_sel      = 2'd3;
    BUZZERBusline = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_note", int'(LEARNBusline), 0);
    chk("reset_done", int'(song_done), 0);
    chk("reset_hit",  int'(hit_cnt), 0);
    chk("reset_miss", int'(miss_cnt), 0);

    // Correct play, cycle by cycle
    for (int i = 0; i < 18; i++) begin
      Status        = vecs[i].status;
      BUZZERBusline = vecs[i].buzz;
      step();
      chk($sformatf("vec%0d_note", i), int'(LEARNBusline), int'(vecs[i].note));
      chk($sformatf("vec%0d_done", i), int'(song_done),    int'(vecs[i].done));
      chk($sformatf("vec%0d_hit",  i), int'(hit_cnt),      int'(vecs[i].hit));
      chk($sformatf("vec%0d_miss", i), int'(miss_cnt),     int'(vecs[i].miss));
    end

    // No keys: every note times out after 8 beats of 4 cycles
    Status        = LEARN_MODE;
    BUZZERBusline = 10'h000;
    measure(10'h001, "miss1");
    measure(10'h002, "miss2");
    measure(10'h004, "miss3");
    repeat (4) step();
    chk("miss_all_cnt",  int'(miss_cnt), 3);
    chk("miss_all_hit",  int'(hit_cnt), 0);
    chk("miss_all_done", int'(song_done), 1);
    Status = FREE_MODE;
    step();
    chk("miss_exit_done", int'(song_done), 0);
    chk("miss_exit_miss", int'(miss_cnt), 3);

    // Held key: hit on note 1, note 2 withheld until release
    Status = LEARN_MODE;
    repeat (3) step();
    chk("hold_first_note", int'(LEARNBusline), 'h001);
    chk("hold_entry_miss", int'(miss_cnt), 0);
    BUZZERBusline = 10'h001;
    step();
    chk("hold_hit", int'(hit_cnt), 1);
    chk("hold_clear", int'(LEARNBusline), 0);
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (LEARNBusline != 10'h000) held_bad++;
    end
    chk("hold_no_next_note", held_bad, 0);
    chk("hold_hit_stable", int'(hit_cnt), 1);
    BUZZERBusline = 10'h000;
    repeat (3) step();
    chk("hold_next_note", int'(LEARNBusline), 'h002);
    Status = FREE_MODE;
    step();

    // Wrong key (do + high) never matches plain do
    Status        = LEARN_MODE;
    BUZZERBusline = 10'h081;
    measure(10'h001, "wrong");
    chk("wrong_hit",  int'(hit_cnt), 0);
    chk("wrong_miss", int'(miss_cnt), 1);
    repeat (5) step();
    chk("wrong_held_release", int'(LEARNBusline), 0);
    BUZZERBusline = 10'h000;
    repeat (3) step();
    chk("wrong_next_note", int'(LEARNBusline), 'h002);
    Status = FREE_MODE;
    step();

    // Leave learn mode while note 2 is showing, then re-enter
    Status = LEARN_MODE;
    repeat (3) step();
    BUZZERBusline = 10'h001;
    step();
    BUZZERBusline = 10'h000;
    repeat (3) step();
    chk("mode_note2", int'(LEARNBusline), 'h002);
    Status = FREE_MODE;
    step();
    chk("mode_exit_note", int'(LEARNBusline), 0);
    chk("mode_exit_done", int'(song_done), 0);
    chk("mode_exit_hit",  int'(hit_cnt), 1);
    step();
    chk("mode_idle_hit", int'(hit_cnt), 1);
    Status = LEARN_MODE;
    step();
    chk("mode_reenter_hit", int'(hit_cnt), 0);
    repeat (2) step();
    chk("mode_reenter_note", int'(LEARNBusline), 'h001);

    // Asynchronous reset while note 2 is showing with one hit scored
    BUZZERBusline = 10'h001;
    step();
    BUZZERBusline = 10'h000;
    repeat (3) step();
    chk("rst_pre_note", int'(LEARNBusline), 'h002);
    chk("rst_pre_hit",  int'(hit_cnt), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_note", int'(LEARNBusline), 0);
    chk("rst_async_hit",  int'(hit_cnt), 0);
    chk("rst_async_done", int'(song_done), 0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("rst_after_note", int'(LEARNBusline), 0);
    step();
    chk("rst_restart_note", int'(LEARNBusline), 'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
